// File: rtl/led_pkg.sv
// Shared types and defaults for the LED matrix note display.
package led_pkg;

    localparam int unsigned DEFAULT_ROWS = 10;
    localparam int unsigned DEFAULT_COLS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } scan_state_e;

    typedef logic [DEFAULT_ROWS-1:0][DEFAULT_COLS-1:0] plane_t;

endpackage

// File: rtl/note_frame_buffer.sv
// Scrolling red/blue frame buffer with single-cycle clear and a row read port.
module note_frame_buffer
    import led_pkg::*;
#(
    parameter int unsigned ROWS   = DEFAULT_ROWS,
    parameter int unsigned COLS   = DEFAULT_COLS,
    parameter int unsigned ADDR_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              clear,
    input  logic [ROWS-1:0]   ins_r,
    input  logic [ROWS-1:0]   ins_b,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COLS-1:0]   rd_r,
    output logic [COLS-1:0]   rd_b
);

    logic [ROWS-1:0][COLS-1:0] red_q, red_d;
    logic [ROWS-1:0][COLS-1:0] blue_q, blue_d;

    // Clear wins over scroll; a scroll drops column 0 and inserts at column COLS-1.
    always_comb begin
        red_d  = red_q;
        blue_d = blue_q;
        if (clear) begin
            red_d  = '0;
            blue_d = '0;
        end else if (step) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                red_d[r]  = {ins_r[r], red_q[r][COLS-1:1]};
                blue_d[r] = {ins_b[r], blue_q[r][COLS-1:1]};
            end
        end
    end

    // Buffer state, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red_q  <= '0;
            blue_q <= '0;
        end else begin
            red_q  <= red_d;
            blue_q <= blue_d;
        end
    end

    // Row read mux feeding the scan snapshot.
    always_comb begin
        rd_r = red_q[rd_addr];
        rd_b = blue_q[rd_addr];
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed LED matrix driver for the scrolling note display.
module led_matrix_scan
    import led_pkg::*;
#(
    parameter int unsigned ROWS     = DEFAULT_ROWS,
    parameter int unsigned COLS     = DEFAULT_COLS,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] note_R,
    input  logic [ROWS-1:0] note_B,
    input  logic [3:0]      offset,
    input  logic            finish,
    output logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_R,
    output logic [COLS-1:0] col_B,
    output logic            frame_tick
);

    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [ROW_W-1:0] RowLast = ROW_W'(ROWS - 1);
    localparam logic [DIV_W-1:0] DivLast = DIV_W'(SCAN_DIV - 1);

    scan_state_e      state_q, state_d;
    logic [3:0]       offset_q;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [ROWS-1:0]  row_n_q, row_n_d;
    logic [COLS-1:0]  col_r_q, col_r_d;
    logic [COLS-1:0]  col_b_q, col_b_d;
    logic             tick_q, tick_d;

    logic            step;
    logic [ROWS-1:0] ins_r, ins_b;
    logic [COLS-1:0] rd_r, rd_b;

    // Any change of the loader pixel counter is one scroll step; offset 0 starts a note column.
    always_comb begin
        step  = (offset != offset_q);
        ins_r = (offset == 4'd0) ? note_R : '0;
        ins_b = (offset == 4'd0) ? note_B : '0;
    end

    note_frame_buffer #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ROW_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .step    (step),
        .clear   (finish),
        .ins_r   (ins_r),
        .ins_b   (ins_b),
        .rd_addr (row_idx_q),
        .rd_r    (rd_r),
        .rd_b    (rd_b)
    );

    // Scan FSM; outputs are computed for the next state so they line up with state_q.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        div_cnt_d = div_cnt_q;
        row_n_d   = row_n_q;
        col_r_d   = col_r_q;
        col_b_d   = col_b_q;
        tick_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StBlank;
                row_n_d = '1;
                col_r_d = '0;
                col_b_d = '0;
            end
            StBlank: begin
                // Snapshot taken here; later scrolls are not seen until the row's next visit.
                state_d   = StShow;
                div_cnt_d = '0;
                row_n_d   = ~(ROWS'(1) << row_idx_q);
                col_r_d   = rd_r;
                col_b_d   = rd_b;
            end
            StShow: begin
                if (div_cnt_q == DivLast) begin
                    state_d   = StBlank;
                    div_cnt_d = '0;
                    row_idx_d = (row_idx_q == RowLast) ? '0 : row_idx_q + ROW_W'(1);
                    row_n_d   = '1;
                    col_r_d   = '0;
                    col_b_d   = '0;
                    tick_d    = (row_idx_q == RowLast);
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Scan state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            offset_q  <= 4'd0;
            row_idx_q <= '0;
            div_cnt_q <= '0;
            row_n_q   <= '1;
            col_r_q   <= '0;
            col_b_q   <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset;
            row_idx_q <= row_idx_d;
            div_cnt_q <= div_cnt_d;
            row_n_q   <= row_n_d;
            col_r_q   <= col_r_d;
            col_b_q   <= col_b_d;
            tick_q    <= tick_d;
        end
    end

    assign row_n      = row_n_q;
    assign col_R      = col_r_q;
    assign col_B      = col_b_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Downstream display stage of the note-scroll path. Takes per-lane note columns (`note_R`, `note_B`), the pixel scroll counter `offset` and the end-of-song `finish` pulse from the note loader. Keeps a scrolling red/blue frame buffer and time-multiplexes it row by row onto the LED matrix row and column drivers.

## Interface
- `ROWS`, 10: matrix rows, one per note lane; equals the loader's note vector width.
- `COLS`, 8: visible columns per colour.
- `SCAN_DIV`, 1000: clock cycles each row is lit (SHOW dwell); must be ≥ 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `note_R`  in  ROWS  red note bits of the current note column, bit i = lane i.
- `note_B`  in  ROWS  blue note bits, same layout.
- `offset`  in  4  loader pixel counter, 0..6; each change of value is one scroll step.
- `finish`  in  1  one-cycle end-of-song pulse.
- `row_n`  out  ROWS  row enables, one-hot active-low; all ones means blanked.
- `col_R`  out  COLS  red column drive, active-high; bit COLS-1 = newest (rightmost) column.
- `col_B`  out  COLS  blue column drive, active-high.
- `frame_tick`  out  1  one-cycle pulse when the last row finishes its dwell.

## Operation
- Frame buffer: ROWS×COLS bits per colour, all zero at reset.
- Scroll detect: `offset_q` registers `offset` (reset 0). `step = (offset != offset_q)`.
- On `step`, every row shifts left one column; column 0 is dropped. Inserted column COLS-1:
  - new `offset == 0`: `note_R` / `note_B` as sampled in the `step` cycle.
  - otherwise: zeros, which gives the inter-note gap.
- `finish` clears both buffers in one cycle. It takes priority over a simultaneous `step`.
- Scan FSM, states in the shared package:
  - IDLE → BLANK, first cycle after reset release.
  - BLANK: lasts one cycle. `row_n` is all ones and `col_*` are 0. Snapshots row `row_idx` of the buffer into `col_R` / `col_B` for the next state. → SHOW.
  - SHOW: `row_n[row_idx] = 0`. Column outputs hold the snapshot, so a scroll during SHOW is not seen until that row's next visit. Runs while `div_cnt` counts 0..SCAN_DIV-1. At SCAN_DIV-1: `row_idx` increments, wrapping ROWS-1→0, `div_cnt` returns to 0, → BLANK.
  - `frame_tick` = 1 on the SHOW→BLANK transition with `row_idx == ROWS-1`.
- Widths:
  - `div_cnt` is $clog2(SCAN_DIV) bits and must not overflow.
  - `row_idx` is $clog2(ROWS) bits; the wrap is explicit, not modulo-power-of-two.

## Timing
- Reset values: `row_n` all ones, `col_R` = `col_B` = 0, `frame_tick` = 0, state IDLE, `row_idx` = 0, `div_cnt` = 0.
- Reset asserted mid-scan forces these values asynchronously. The buffer clears.
- All outputs are registered; there is no combinational path from input to output.
- Scroll latency:
  - `offset` changes at cycle t; buffer updated at t+1.
  - Visible at the next BLANK snapshot of each row, at most ROWS·(SCAN_DIV+1) cycles later.
- Frame period: ROWS·(SCAN_DIV+1) cycles. Exactly one row enable is low during SHOW; none is low in BLANK or IDLE.
- Back-to-back offset changes on consecutive cycles each cause one shift.
- An `offset` held constant causes no shift.

## Structure
- Package `led_pkg`: ROWS/COLS defaults, scan state enum (IDLE, BLANK, SHOW), colour-plane type `logic [ROWS-1:0][COLS-1:0]`.
- Sub-module `note_frame_buffer`:
  - Ports: clk, rst, step, clear, insert column, row read address.
  - Contains the per-colour shift/insert/clear logic and the row read mux.
- The top contains the scroll detect, the scan FSM and the output registers.

## Test plan
- Reset, then release with SCAN_DIV=4:
  - `row_n` = 10'h3FF.
  - First cycle after entering SHOW: `row_n` = 10'h3FE. Each row is lit 4 cycles, with 1 blank cycle between rows.
  - `frame_tick` every 50 cycles.
- Note insert: `note_R` = 10'b0000000101, `offset` 6→0.
  - Next snapshot of row 0: `col_R` = 8'h80. Row 2 the same; row 1 `col_R` = 0.
  - Then 7 more offset steps (1..6, 0 with `note_R` = 0) → row 0 `col_R` = 8'h01.
- Blue vs red: `note_B` = 10'h200 with `note_R` = 0 on insert → row 9 `col_B` = 8'h80, `col_R` = 0.
- `finish` and an offset change in the same cycle → buffer all zero. Every row shows 0 on the following frame.
- Assert `rst` = 0 mid-SHOW on row 5 → `row_n` = 10'h3FF immediately. After release, the scan restarts at row 0 with an empty buffer.
- Hold `offset` constant for 3 frames → buffer unchanged. The `col_*` snapshot per row is identical in every frame.
